// File: rtl/rs_scheduler.sv
// rs_scheduler: ALU reservation station and issue scheduler.
// Holds decoded non-memory instructions until both operands are ready. It
// snoops the ALU and LSB result broadcasts to wake waiting operands, and sends
// the lowest-index ready entry to the single-cycle ALU on each cycle.
module rs_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              issue_rs_ready,
  input  logic [ROB_W-1:0]  issue_rob_index,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_rs1_val,
  input  logic [ROB_W-1:0]  issue_rs1_depend,
  input  logic [DATA_W-1:0] issue_rs2_val,
  input  logic [ROB_W-1:0]  issue_rs2_depend,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic [DATA_W-1:0] issue_PC,
  input  logic              issue_pred_br,
  input  logic              alu_ready,
  input  logic [ROB_W-1:0]  alu_rob_index,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              lsb_ready,
  input  logic [ROB_W-1:0]  lsb_rob_index,
  input  logic [DATA_W-1:0] lsb_result,
  output logic              rs_full,
  output logic              rs_to_alu_valid,
  output logic [OP_W-1:0]   rs_to_alu_op,
  output logic [DATA_W-1:0] rs_to_alu_rs1_val,
  output logic [DATA_W-1:0] rs_to_alu_rs2_val,
  output logic [DATA_W-1:0] rs_to_alu_imm,
  output logic [DATA_W-1:0] rs_to_alu_PC,
  output logic [ROB_W-1:0]  rs_to_alu_rob_index,
  output logic              rs_to_alu_pred_br
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  // Entry storage. Only busy is control state; the payload needs no reset.
  logic [RS_SIZE-1:0] busy;
  logic [OP_W-1:0]    ent_op      [RS_SIZE];
  logic [DATA_W-1:0]  ent_rs1_val [RS_SIZE];
  logic [ROB_W-1:0]   ent_rs1_dep [RS_SIZE];
  logic [DATA_W-1:0]  ent_rs2_val [RS_SIZE];
  logic [ROB_W-1:0]   ent_rs2_dep [RS_SIZE];
  logic [DATA_W-1:0]  ent_imm     [RS_SIZE];
  logic [DATA_W-1:0]  ent_pc      [RS_SIZE];
  logic [ROB_W-1:0]   ent_rob     [RS_SIZE];
  logic               ent_pred    [RS_SIZE];

  // Stage p0: select signals computed from the state before the edge.
  logic [RS_SIZE-1:0] ready;
  logic               vld_p0;
  logic [IDX_W-1:0]   sel_idx_p0;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               advance;
  logic               alloc;

  // Stage p1: registered dispatch toward the ALU.
  logic               vld_p1;
  logic [OP_W-1:0]    op_p1;
  logic [DATA_W-1:0]  rs1_val_p1;
  logic [DATA_W-1:0]  rs2_val_p1;
  logic [DATA_W-1:0]  imm_p1;
  logic [DATA_W-1:0]  pc_p1;
  logic [ROB_W-1:0]   rob_p1;
  logic               pred_p1;

  // A waiting tag is cleared when either broadcast carries it. Tag 0 never waits.
  function automatic logic [ROB_W-1:0] wake_dep(input logic [ROB_W-1:0] dep);
    logic hit;
    hit = (dep != '0) &&
          ((alu_ready && (dep == alu_rob_index)) ||
           (lsb_ready && (dep == lsb_rob_index)));
    return hit ? '0 : dep;
  endfunction

  // The operand value follows the broadcast that woke it. ALU wins if both match.
  function automatic logic [DATA_W-1:0] wake_val(input logic [ROB_W-1:0] dep,
                                                 input logic [DATA_W-1:0] val);
    logic [DATA_W-1:0] res;
    res = val;
    if (dep != '0) begin
      if (alu_ready && (dep == alu_rob_index)) begin
        res = alu_result;
      end else if (lsb_ready && (dep == lsb_rob_index)) begin
        res = lsb_result;
      end
    end
    return res;
  endfunction

  assign advance = rdy_in && !rst_in && !clr_in;
  assign rs_full = &busy;
  // When the station is full there is no free slot, so an illegal issue is dropped.
  assign alloc   = advance && issue_rs_ready && free_found;

  // Mark an entry ready when it is busy and both operand tags are clear.
  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy[i] && (ent_rs1_dep[i] == '0) && (ent_rs2_dep[i] == '0);
    end
  end

  // Lowest-index ready entry: scan from the top so the lowest match is written last.
  always_comb begin
    vld_p0     = 1'b0;
    sel_idx_p0 = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        vld_p0     = 1'b1;
        sel_idx_p0 = IDX_W'(i);
      end
    end
  end

  // Lowest-index free entry, from the busy bits before the edge. A slot being
  // freed by dispatch in this cycle is not reused until the next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Busy bits: flush or reset empties the station. Dispatch and allocation never
  // hit the same slot, because one needs busy=1 and the other needs busy=0.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      busy <= '0;
    end else if (rdy_in) begin
      if (vld_p0) begin
        busy[sel_idx_p0] <= 1'b0;
      end
      if (alloc) begin
        busy[free_idx] <= 1'b1;
      end
    end
  end

  // Entry payload: wake operands of busy entries and write a newly issued entry.
  // An incoming entry also snoops the broadcasts in its own cycle.
  always_ff @(posedge clk_in) begin
    if (advance) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          ent_rs1_dep[i] <= wake_dep(ent_rs1_dep[i]);
          ent_rs1_val[i] <= wake_val(ent_rs1_dep[i], ent_rs1_val[i]);
          ent_rs2_dep[i] <= wake_dep(ent_rs2_dep[i]);
          ent_rs2_val[i] <= wake_val(ent_rs2_dep[i], ent_rs2_val[i]);
        end
      end
      if (alloc) begin
        ent_op[free_idx]      <= issue_op;
        ent_imm[free_idx]     <= issue_imm;
        ent_pc[free_idx]      <= issue_PC;
        ent_rob[free_idx]     <= issue_rob_index;
        ent_pred[free_idx]    <= issue_pred_br;
        ent_rs1_dep[free_idx] <= wake_dep(issue_rs1_depend);
        ent_rs1_val[free_idx] <= wake_val(issue_rs1_depend, issue_rs1_val);
        ent_rs2_dep[free_idx] <= wake_dep(issue_rs2_depend);
        ent_rs2_val[free_idx] <= wake_val(issue_rs2_depend, issue_rs2_val);
      end
    end
  end

  // ---- stage p0 -> p1 boundary ----
  // Dispatch valid: set only when the station advances and an entry was selected.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= advance && vld_p0;
    end
  end

  // Dispatch payload: cleared on reset and held while nothing is dispatched.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      op_p1      <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
      imm_p1     <= '0;
      pc_p1      <= '0;
      rob_p1     <= '0;
      pred_p1    <= 1'b0;
    end else if (advance && vld_p0) begin
      op_p1      <= ent_op[sel_idx_p0];
      rs1_val_p1 <= ent_rs1_val[sel_idx_p0];
      rs2_val_p1 <= ent_rs2_val[sel_idx_p0];
      imm_p1     <= ent_imm[sel_idx_p0];
      pc_p1      <= ent_pc[sel_idx_p0];
      rob_p1     <= ent_rob[sel_idx_p0];
      pred_p1    <= ent_pred[sel_idx_p0];
    end
  end

  assign rs_to_alu_valid     = vld_p1;
  assign rs_to_alu_op        = op_p1;
  assign rs_to_alu_rs1_val   = rs1_val_p1;
  assign rs_to_alu_rs2_val   = rs2_val_p1;
  assign rs_to_alu_imm       = imm_p1;
  assign rs_to_alu_PC        = pc_p1;
  assign rs_to_alu_rob_index = rob_p1;
  assign rs_to_alu_pred_br   = pred_p1;

  // The decoder must stall while the station is full.
  issue_while_full_a: assert property (@(posedge clk_in) disable iff (rst_in)
    !(rdy_in && !clr_in && issue_rs_ready && rs_full));

endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler: directed scenarios followed by randomized traffic,
// all compared against a slot-level behavioural model of the station.
module tb_rs_scheduler;
  localparam int N  = 16;
  localparam int RW = 4;
  localparam int OW = 6;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clr_in;
  logic          issue_rs_ready;
  logic [RW-1:0] issue_rob_index;
  logic [OW-1:0] issue_op;
  logic [DW-1:0] issue_rs1_val;
  logic [RW-1:0] issue_rs1_depend;
  logic [DW-1:0] issue_rs2_val;
  logic [RW-1:0] issue_rs2_depend;
  logic [DW-1:0] issue_imm;
  logic [DW-1:0] issue_PC;
  logic          issue_pred_br;
  logic          alu_ready;
  logic [RW-1:0] alu_rob_index;
  logic [DW-1:0] alu_result;
  logic          lsb_ready;
  logic [RW-1:0] lsb_rob_index;
  logic [DW-1:0] lsb_result;
  logic          rs_full;
  logic          rs_to_alu_valid;
  logic [OW-1:0] rs_to_alu_op;
  logic [DW-1:0] rs_to_alu_rs1_val;
  logic [DW-1:0] rs_to_alu_rs2_val;
  logic [DW-1:0] rs_to_alu_imm;
  logic [DW-1:0] rs_to_alu_PC;
  logic [RW-1:0] rs_to_alu_rob_index;
  logic          rs_to_alu_pred_br;

  rs_scheduler #(.RS_SIZE(N), .ROB_W(RW), .OP_W(OW), .DATA_W(DW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .issue_rs_ready(issue_rs_ready), .issue_rob_index(issue_rob_index),
    .issue_op(issue_op), .issue_rs1_val(issue_rs1_val),
    .issue_rs1_depend(issue_rs1_depend), .issue_rs2_val(issue_rs2_val),
    .issue_rs2_depend(issue_rs2_depend), .issue_imm(issue_imm),
    .issue_PC(issue_PC), .issue_pred_br(issue_pred_br),
    .alu_ready(alu_ready), .alu_rob_index(alu_rob_index), .alu_result(alu_result),
    .lsb_ready(lsb_ready), .lsb_rob_index(lsb_rob_index), .lsb_result(lsb_result),
    .rs_full(rs_full), .rs_to_alu_valid(rs_to_alu_valid),
    .rs_to_alu_op(rs_to_alu_op), .rs_to_alu_rs1_val(rs_to_alu_rs1_val),
    .rs_to_alu_rs2_val(rs_to_alu_rs2_val), .rs_to_alu_imm(rs_to_alu_imm),
    .rs_to_alu_PC(rs_to_alu_PC), .rs_to_alu_rob_index(rs_to_alu_rob_index),
    .rs_to_alu_pred_br(rs_to_alu_pred_br)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit            busy;
    logic [OW-1:0] op;
    logic [DW-1:0] v1, v2, imm, pc;
    logic [RW-1:0] d1, d2, rob;
    logic          pb;
  } ent_t;

  ent_t         m [N];
  logic         m_valid = 1'b0;
  logic [159:0] m_out   = '0;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [159:0] pack(input ent_t e);
    return 160'({e.op, e.v1, e.v2, e.imm, e.pc, e.rob, e.pb});
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < N; i++) if (m[i].busy) n++;
    return n;
  endfunction

  // Resolve an operand against this cycle's broadcasts: returns {dep, value}.
  function automatic logic [RW+DW-1:0] snoop(input logic [RW-1:0] d, input logic [DW-1:0] v);
    if (d != 0 && alu_ready && d == alu_rob_index) return {4'd0, alu_result};
    if (d != 0 && lsb_ready && d == lsb_rob_index) return {4'd0, lsb_result};
    return {d, v};
  endfunction

  // Apply one clock edge to the model, using the inputs the DUT will sample.
  task automatic model_edge();
    int sel = -1;
    int fr  = -1;
    if (rst_in) begin
      foreach (m[i]) m[i].busy = 0;
      m_valid = 0;
      m_out   = '0;
      return;
    end
    if (clr_in) begin
      foreach (m[i]) m[i].busy = 0;
      m_valid = 0;
      return;
    end
    if (!rdy_in) begin
      m_valid = 0;
      return;
    end
    for (int i = 0; i < N; i++)
      if (sel < 0 && m[i].busy && m[i].d1 == 0 && m[i].d2 == 0) sel = i;
    for (int i = 0; i < N; i++)
      if (fr < 0 && !m[i].busy) fr = i;
    m_valid = (sel >= 0);
    if (sel >= 0) begin
      m_out = pack(m[sel]);
      m[sel].busy = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy) begin
        {m[i].d1, m[i].v1} = snoop(m[i].d1, m[i].v1);
        {m[i].d2, m[i].v2} = snoop(m[i].d2, m[i].v2);
      end
    end
    if (issue_rs_ready && fr >= 0) begin
      m[fr].busy = 1;
      m[fr].op   = issue_op;
      m[fr].imm  = issue_imm;
      m[fr].pc   = issue_PC;
      m[fr].rob  = issue_rob_index;
      m[fr].pb   = issue_pred_br;
      {m[fr].d1, m[fr].v1} = snoop(issue_rs1_depend, issue_rs1_val);
      {m[fr].d2, m[fr].v2} = snoop(issue_rs2_depend, issue_rs2_val);
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk_in);
    #1;
    chk("valid", rs_to_alu_valid, m_valid);
    chk("full", rs_full, m_count() == N);
    chk("payload", {rs_to_alu_op, rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm,
                    rs_to_alu_PC, rs_to_alu_rob_index, rs_to_alu_pred_br}, m_out);
  endtask

  task automatic idle();
    rst_in = 0; clr_in = 0; rdy_in = 1;
    issue_rs_ready = 0; issue_rob_index = 0; issue_op = 0;
    issue_rs1_val = 0; issue_rs1_depend = 0; issue_rs2_val = 0; issue_rs2_depend = 0;
    issue_imm = 0; issue_PC = 0; issue_pred_br = 0;
    alu_ready = 0; alu_rob_index = 0; alu_result = 0;
    lsb_ready = 0; lsb_rob_index = 0; lsb_result = 0;
  endtask

  task automatic issue(input logic [RW-1:0] rob, input logic [OW-1:0] op,
                       input logic [DW-1:0] v1, input logic [RW-1:0] d1,
                       input logic [DW-1:0] v2, input logic [RW-1:0] d2,
                       input logic [DW-1:0] imm, input logic [DW-1:0] pc);
    issue_rs_ready = 1; issue_rob_index = rob; issue_op = op;
    issue_rs1_val = v1; issue_rs1_depend = d1; issue_rs2_val = v2; issue_rs2_depend = d2;
    issue_imm = imm; issue_PC = pc; issue_pred_br = pc[2];
  endtask

  task automatic do_reset();
    idle(); rst_in = 1; cyc(); cyc(); idle();
  endtask

  initial begin
    int t;
    foreach (m[i]) m[i].busy = 0;
    do_reset();
    chk("rst_valid", rs_to_alu_valid, 0);
    chk("rst_full", rs_full, 0);
    chk("rst_rob", rs_to_alu_rob_index, 0);

    // Test 1: ready entry dispatches the very next cycle.
    issue(3, 6'd1, 5, 0, 0, 0, 7, 32'h100); cyc(); idle();
    cyc();
    chk("t1_valid", rs_to_alu_valid, 1);
    chk("t1_rob", rs_to_alu_rob_index, 3);
    chk("t1_rs1", rs_to_alu_rs1_val, 5);
    chk("t1_imm", rs_to_alu_imm, 7);
    cyc();
    chk("t1_after", rs_to_alu_valid, 0);

    // Test 2: ALU wakeup.
    do_reset();
    issue(4, 6'd2, 32'hDEAD, 2, 9, 0, 1, 32'h200); cyc(); idle();
    cyc(); chk("t2_wait", rs_to_alu_valid, 0);
    alu_ready = 1; alu_rob_index = 2; alu_result = 32'h10;
    cyc(); chk("t2_wake_edge", rs_to_alu_valid, 0); idle();
    cyc();
    chk("t2_valid", rs_to_alu_valid, 1);
    chk("t2_rs1", rs_to_alu_rs1_val, 32'h10);
    chk("t2_rob", rs_to_alu_rob_index, 4);

    // Test 3: younger ready entry bypasses the older waiting one; LSB wakeup.
    do_reset();
    issue(5, 6'd3, 0, 6, 3, 0, 0, 32'h300); cyc();
    issue(7, 6'd4, 1, 0, 2, 0, 0, 32'h304); cyc(); idle();
    cyc(); chk("t3_first", rs_to_alu_rob_index, 7);
    lsb_ready = 1; lsb_rob_index = 6; lsb_result = 32'hAB;
    cyc(); chk("t3_wake_edge", rs_to_alu_valid, 0); idle();
    cyc();
    chk("t3_second", rs_to_alu_rob_index, 5);
    chk("t3_rs1", rs_to_alu_rs1_val, 32'hAB);

    // Test 4: fill every entry, then release them all at once.
    do_reset();
    for (int i = 0; i < N; i++) begin
      issue(RW'((i % 15) + 1), 6'd5, 0, 9, 0, 9, i, 32'h400 + 4 * i); cyc();
    end
    idle();
    chk("t4_full", rs_full, 1);
    alu_ready = 1; alu_rob_index = 9; alu_result = 32'h99;
    cyc(); idle();
    for (int i = 0; i < N; i++) begin
      cyc();
      chk("t4_order", rs_to_alu_imm, i);
      if (i == 0) chk("t4_full_drop", rs_full, 0);
    end
    cyc(); chk("t4_done", rs_to_alu_valid, 0);

    // Test 5: flush with a simultaneous issue.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(RW'(i + 1), 6'd6, 0, 11, 0, 0, 0, 0); cyc();
    end
    idle(); clr_in = 1; issue(12, 6'd7, 1, 0, 1, 0, 0, 0);
    cyc(); idle();
    chk("t5_full", rs_full, 0);
    alu_ready = 1; alu_rob_index = 11; alu_result = 32'h55;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("t5_none", rs_to_alu_valid, 0);
    end
    idle();

    // Test 6: freeze blocks dispatch, wakeup and issue.
    do_reset();
    issue(2, 6'd8, 0, 12, 0, 0, 0, 32'h600); cyc();
    issue(8, 6'd9, 32'h1234, 0, 32'h5678, 0, 32'h42, 32'h604); cyc(); idle();
    rdy_in = 0; alu_ready = 1; alu_rob_index = 12; alu_result = 32'h77;
    issue(3, 6'd1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("t6_frozen", rs_to_alu_valid, 0);
    end
    idle();
    cyc();
    chk("t6_rob", rs_to_alu_rob_index, 8);
    chk("t6_rs1", rs_to_alu_rs1_val, 32'h1234);
    chk("t6_rs2", rs_to_alu_rs2_val, 32'h5678);
    cyc(); chk("t6_nowake", rs_to_alu_valid, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      idle();
      rst_in = ($urandom_range(0, 299) == 0);
      clr_in = ($urandom_range(0, 59) == 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      if (m_count() < N && $urandom_range(0, 1) == 1) begin
        issue(RW'($urandom_range(1, 15)), OW'($urandom), $urandom,
              ($urandom_range(0, 9) < 4) ? RW'($urandom_range(1, 15)) : 4'd0,
              $urandom,
              ($urandom_range(0, 9) < 4) ? RW'($urandom_range(1, 15)) : 4'd0,
              $urandom, $urandom);
      end
      if ($urandom_range(0, 9) < 4) begin
        alu_ready = 1; alu_rob_index = RW'($urandom_range(1, 15)); alu_result = $urandom;
      end
      if ($urandom_range(0, 9) < 4) begin
        t = $urandom_range(1, 15);
        while (alu_ready && RW'(t) == alu_rob_index) t = $urandom_range(1, 15);
        lsb_ready = 1; lsb_rob_index = RW'(t); lsb_result = $urandom;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rs_scheduler.md
Name: rs_scheduler

Overview:
- Reservation station and issue scheduler for the ALU.
- Accepts decoded non-memory instructions from the decoder and holds them until their operands are ready.
- Snoops the ALU and LSB result broadcasts to wake waiting operands.
- Each cycle, dispatches at most one ready entry to the single-cycle ALU, lowest-index ready entry first.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- ROB_W, 4, ROB index width. Index 0 means "no dependency" and is never a valid rename tag.
- OP_W, 6, width of the operation enum.
- DATA_W, 32, data/address width.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low freezes the block
- clr_in  in  1  misprediction flush
- issue_rs_ready  in  1  decoder writes one entry this cycle
- issue_rob_index  in  ROB_W  destination ROB tag
- issue_op  in  OP_W  operation enum
- issue_rs1_val  in  DATA_W  operand 1 value
- issue_rs1_depend  in  ROB_W  operand 1 tag; 0 means value valid
- issue_rs2_val  in  DATA_W  operand 2 value
- issue_rs2_depend  in  ROB_W  operand 2 tag; 0 means value valid
- issue_imm  in  DATA_W  immediate
- issue_PC  in  DATA_W  instruction PC
- issue_pred_br  in  1  predicted-taken flag
- alu_ready  in  1  ALU broadcast valid
- alu_rob_index  in  ROB_W  ALU broadcast tag
- alu_result  in  DATA_W  ALU broadcast value
- lsb_ready  in  1  LSB broadcast valid
- lsb_rob_index  in  ROB_W  LSB broadcast tag
- lsb_result  in  DATA_W  LSB broadcast value
- rs_full  out  1  no free entry (registered state, combinational decode)
- rs_to_alu_valid  out  1  dispatch valid
- rs_to_alu_op  out  OP_W  dispatched operation
- rs_to_alu_rs1_val  out  DATA_W  dispatched operand 1
- rs_to_alu_rs2_val  out  DATA_W  dispatched operand 2
- rs_to_alu_imm  out  DATA_W  dispatched immediate
- rs_to_alu_PC  out  DATA_W  dispatched PC
- rs_to_alu_rob_index  out  ROB_W  dispatched ROB tag
- rs_to_alu_pred_br  out  1  dispatched prediction flag

Behaviour:

Entry state:
- Per entry: busy, op, rs1_val/dep, rs2_val/dep, imm, PC, rob_index, pred_br.
- An entry is ready when busy, rs1_dep==0 and rs2_dep==0.

Reset / flush:
- rst_in or clr_in at a clock edge clears all busy bits and sets rs_to_alu_valid=0 next cycle.
- All rs_to_alu_* data outputs reset to 0.
- rst_in has priority over rdy_in; so does clr_in.
- A flush in the same cycle as issue_rs_ready drops the incoming entry.

Freeze:
- rdy_in=0 (no reset or clear): no state change; rs_to_alu_valid=0 next cycle; incoming issue ignored.

Allocation:
- On issue_rs_ready, write the lowest-index free entry; busy=1.
- Incoming deps are compared against this cycle's ALU/LSB broadcasts. On a match, the value is captured and the dep written as 0.

Wakeup:
- Every cycle, for each busy entry and each operand with dep!=0:
  - if alu_ready and dep==alu_rob_index, load alu_result and clear dep;
  - else if lsb_ready and dep==lsb_rob_index, load lsb_result and clear dep.
- The ALU broadcast has priority; the tags are guaranteed distinct anyway.

Dispatch:
- Combinational select of the lowest-index ready entry, using state before the edge.
- At the edge: register its fields onto rs_to_alu_*, set rs_to_alu_valid=1, clear its busy bit.
- With no ready entry, rs_to_alu_valid=0 and data outputs hold their last values.
- The ALU accepts every cycle; there is no backpressure.
- Latency: an entry written with both deps 0 at edge t dispatches at edge t+1 and appears at the ALU in cycle t+1.
- An operand woken at edge t makes its entry eligible at edge t+1.

Simultaneous events:
- Allocation and dispatch may occur in the same cycle.
- The freed entry is not reusable until the next cycle; allocation picks from busy bits before the edge.
- The same entry can never be both allocated and dispatched in one cycle.

rs_full:
- rs_full=1 when all RS_SIZE entries are busy. It ignores a same-cycle dispatch (conservative).
- Issue while full is illegal: the decoder stalls. The block asserts on it in simulation and drops the entry.

Arithmetic:
- A busy counter is not required; full is computed as the AND of the busy bits.

Test Plan:
1. Reset, then issue ADDI (rob=3, deps 0, rs1=5, imm=7) -> next cycle rs_to_alu_valid=1, rob=3, rs1_val=5, imm=7; the following cycle valid=0.
2. Issue entry rob=4 with rs1_dep=2; two cycles later alu_ready with tag 2, result 0x10 -> dispatch one cycle after the broadcast with rs1_val=0x10. No dispatch before that.
3. Issue rob=5 (dep lsb tag 6) then rob=7 (deps 0) -> rob=7 dispatches first. After lsb_ready tag 6 with value 0xAB, rob=5 dispatches with 0xAB.
4. Fill 16 entries, all dependent on tag 9 -> rs_full=1. Broadcast ALU tag 9 -> entries dispatch in index order 0..15, one per cycle. rs_full drops the cycle after the first dispatch.
5. With 3 entries busy, assert clr_in together with issue_rs_ready -> next cycle rs_full=0, no dispatch ever from old entries, incoming entry dropped.
6. Hold rdy_in=0 for 3 cycles with a ready entry and a broadcast present -> no dispatch and no wakeup. When rdy_in returns, the entry dispatches the next cycle with its original values.
